// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART TX source arbiter.
package uart_tx_arbiter_pkg;

  localparam int UART_TX_BAUD_PERIOD = 868;
  localparam int DEFAULT_BAUD_PERIOD = UART_TX_BAUD_PERIOD;

  typedef enum logic [1:0] {
    ST_ACTIVE      = 2'd0,
    ST_SWITCH_WAIT = 2'd1,
    ST_GUARD       = 2'd2
  } arb_state_e;

  // Bits needed to hold values 0..value-1; used with (limit+1) for counter widths.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Serial lines, source request and status flags around the TXD arbiter.
interface uart_tx_arbiter_if;
  logic uart_tx_cpu;
  logic uart_tx_ocd;
  logic debug_uart_tx_sel_ocd1_cpu0;
  logic TXD;
  logic active_sel_ocd1_cpu0;
  logic switch_pending;
  logic forced_switch;

  modport master (
    output uart_tx_cpu, uart_tx_ocd, debug_uart_tx_sel_ocd1_cpu0,
    input  TXD, active_sel_ocd1_cpu0, switch_pending, forced_switch
  );

  modport slave (
    input  uart_tx_cpu, uart_tx_ocd, debug_uart_tx_sel_ocd1_cpu0,
    output TXD, active_sel_ocd1_cpu0, switch_pending, forced_switch
  );
endinterface

// File: rtl/uart_tx_arbiter_idle_detector.sv
// Registers one UART line and flags it idle after LIMIT consecutive mark samples.
// One cycle of input latency; no backpressure.
module uart_idle_detector
  import uart_tx_arbiter_pkg::*;
#(
  parameter int LIMIT = 44
) (
  input  logic clk,
  input  logic sync_reset,
  input  logic line_i,
  output logic line_q_o,
  output logic idle_o
);

  localparam int W = clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic         line_q;
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Any space sample restarts the mark run; the count then holds at LIM.
  always_comb begin
    cnt_d = cnt_q;
    if (!line_q) begin
      cnt_d = '0;
    end else if (cnt_q != LIM) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      line_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      line_q <= line_i;
      cnt_q  <= cnt_d;
    end
  end

  assign line_q_o = line_q;
  assign idle_o   = (cnt_q == LIM);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-safe TXD source arbiter: switches between CPU and OCD UARTs only across idle gaps.
// Source to TXD is 2 cycles outside GUARD; no backpressure, the request is a level.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int   BAUD_PERIOD  = DEFAULT_BAUD_PERIOD,
  parameter int   IDLE_BITS    = 11,
  parameter int   GUARD_BITS   = 1,
  parameter int   TIMEOUT_BITS = 110,
  parameter logic RESET_SEL    = 1'b1
) (
  input logic               clk,
  input logic               sync_reset,
  uart_tx_arbiter_if.slave  bus
);

  localparam int IDLE_LIM  = BAUD_PERIOD * IDLE_BITS;
  localparam int GUARD_LIM = BAUD_PERIOD * GUARD_BITS;
  localparam int TO_LIM    = BAUD_PERIOD * TIMEOUT_BITS;
  localparam int GW        = clog2(GUARD_LIM + 1);
  localparam int TW        = clog2(TO_LIM + 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_LIM - 1);
  localparam logic [TW-1:0] TO_MAX     = TW'(TO_LIM);

  logic cpu_q, ocd_q, cpu_idle, ocd_idle;

  uart_idle_detector #(.LIMIT(IDLE_LIM)) u_idle_cpu (
    .clk        (clk),
    .sync_reset (sync_reset),
    .line_i     (bus.uart_tx_cpu),
    .line_q_o   (cpu_q),
    .idle_o     (cpu_idle)
  );

  uart_idle_detector #(.LIMIT(IDLE_LIM)) u_idle_ocd (
    .clk        (clk),
    .sync_reset (sync_reset),
    .line_i     (bus.uart_tx_ocd),
    .line_q_o   (ocd_q),
    .idle_o     (ocd_idle)
  );

  arb_state_e    state_q, state_d;
  logic          sel_q, sel_d;
  logic          txd_q, txd_d;
  logic          pend_q, pend_d;
  logic          forced_q, forced_d;
  logic [GW-1:0] guard_cnt_q, guard_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  logic req, act_line, act_idle, oth_idle;

  assign req      = bus.debug_uart_tx_sel_ocd1_cpu0;
  assign act_line = sel_q ? ocd_q : cpu_q;
  assign act_idle = sel_q ? ocd_idle : cpu_idle;
  assign oth_idle = sel_q ? cpu_idle : ocd_idle;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    txd_d       = act_line;
    forced_d    = 1'b0;
    guard_cnt_d = guard_cnt_q;
    to_cnt_d    = to_cnt_q;
    unique case (state_q)
      ST_ACTIVE: begin
        if (req != sel_q) begin
          state_d  = ST_SWITCH_WAIT;
          to_cnt_d = '0;
        end
      end
      ST_SWITCH_WAIT: begin
        if (to_cnt_q != TO_MAX) to_cnt_d = to_cnt_q + TW'(1);
        if (req == sel_q) begin
          state_d = ST_ACTIVE;
        end else if (oth_idle && (act_idle || (to_cnt_q == TO_MAX))) begin
          // Incoming line must be idle either way; forced only if the old line never quietened.
          state_d     = ST_GUARD;
          sel_d       = ~sel_q;
          txd_d       = 1'b1;
          guard_cnt_d = '0;
          forced_d    = !act_idle;
        end
      end
      ST_GUARD: begin
        txd_d = 1'b1;
        if (guard_cnt_q == GUARD_LAST) begin
          // Last guard cycle loads the new source so the 2-cycle latency holds on exit.
          state_d = ST_ACTIVE;
          txd_d   = act_line;
        end else begin
          guard_cnt_d = guard_cnt_q + GW'(1);
        end
      end
      default: state_d = ST_ACTIVE;
    endcase
    pend_d = (state_d != ST_ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q     <= ST_ACTIVE;
      sel_q       <= RESET_SEL;
      txd_q       <= 1'b1;
      pend_q      <= 1'b0;
      forced_q    <= 1'b0;
      guard_cnt_q <= '0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      txd_q       <= txd_d;
      pend_q      <= pend_d;
      forced_q    <= forced_d;
      guard_cnt_q <= guard_cnt_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign bus.TXD                  = txd_q;
  assign bus.active_sel_ocd1_cpu0 = sel_q;
  assign bus.switch_pending       = pend_q;
  assign bus.forced_switch        = forced_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with BAUD_PERIOD=4 (idle 44, guard 4, timeout 80 cycles).
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic sync_reset;
  int   tests = 0;
  int   fails = 0;
  int   forced_cnt = 0;
  logic ocd_p1, ocd_p2, cpu_p1, cpu_p2;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(
    .BAUD_PERIOD  (4),
    .IDLE_BITS    (11),
    .GUARD_BITS   (1),
    .TIMEOUT_BITS (20),
    .RESET_SEL    (1'b1)
  ) dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  // At a negedge: record drive history, apply new inputs. Afterwards TXD should equal *_p2.
  task automatic step(input logic o, input logic c, input logic s, input logic r);
    @(negedge clk);
    ocd_p2 = ocd_p1;
    ocd_p1 = bus.uart_tx_ocd;
    cpu_p2 = cpu_p1;
    cpu_p1 = bus.uart_tx_cpu;
    if (bus.forced_switch) forced_cnt++;
    bus.uart_tx_ocd = o;
    bus.uart_tx_cpu = c;
    bus.debug_uart_tx_sel_ocd1_cpu0 = s;
    sync_reset = r;
  endtask

  task automatic idle(input int n, input logic s);
    repeat (n) step(1'b1, 1'b1, s, 1'b0);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1);
      tests++;
      if (bus.TXD !== 1'b1) begin fails++; $display("FAIL reset_txd: got %b want 1", bus.TXD); end
    end
    tests++;
    if (bus.active_sel_ocd1_cpu0 !== 1'b1) begin fails++; $display("FAIL reset_sel: got %b want 1", bus.active_sel_ocd1_cpu0); end
    tests++;
    if (bus.switch_pending !== 1'b0) begin fails++; $display("FAIL reset_pending: got %b want 0", bus.switch_pending); end
    tests++;
    if (bus.forced_switch !== 1'b0) begin fails++; $display("FAIL reset_forced: got %b want 0", bus.forced_switch); end
    step(1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_passthrough;
    logic [15:0] pat;
    pat = 16'b1011_0010_0111_0100;
    for (int i = 0; i < 16; i++) begin
      step(pat[i], ~pat[i], 1'b1, 1'b0);
      if (i >= 2) begin
        tests++;
        if (bus.TXD !== ocd_p2) begin fails++; $display("FAIL pass_txd[%0d]: got %b want %b", i, bus.TXD, ocd_p2); end
      end
    end
  endtask

  task automatic test_clean_switch;
    idle(50, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    tests++;
    if (bus.switch_pending !== 1'b0) begin fails++; $display("FAIL sw_pend_pre: got %b want 0", bus.switch_pending); end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    tests++;
    if (bus.switch_pending !== 1'b1 || bus.active_sel_ocd1_cpu0 !== 1'b1)
      begin fails++; $display("FAIL sw_wait: got pend=%b sel=%b want 1 1", bus.switch_pending, bus.active_sel_ocd1_cpu0); end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    tests++;
    if (bus.active_sel_ocd1_cpu0 !== 1'b0) begin fails++; $display("FAIL sw_sel: got %b want 0", bus.active_sel_ocd1_cpu0); end
    tests++;
    if (bus.TXD !== 1'b1) begin fails++; $display("FAIL sw_guard0: got %b want 1", bus.TXD); end
    for (int i = 1; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      tests++;
      if (bus.TXD !== 1'b1 || bus.switch_pending !== 1'b1)
        begin fails++; $display("FAIL sw_guard%0d: got txd=%b pend=%b want 1 1", i, bus.TXD, bus.switch_pending); end
    end
    // CPU low since the guard began, so TXD drops on the first ACTIVE cycle.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    tests++;
    if (bus.TXD !== 1'b0 || bus.switch_pending !== 1'b0)
      begin fails++; $display("FAIL sw_exit: got txd=%b pend=%b want 0 0", bus.TXD, bus.switch_pending); end
    for (int i = 0; i < 12; i++) begin
      step(~i[1], i[1] ^ i[0], 1'b0, 1'b0);
      tests++;
      if (bus.TXD !== cpu_p2) begin fails++; $display("FAIL sw_cpu[%0d]: got %b want %b", i, bus.TXD, cpu_p2); end
    end
  endtask

  task automatic go_ocd;
    idle(50, 1'b0);
    idle(12, 1'b1);
    tests++;
    if (bus.active_sel_ocd1_cpu0 !== 1'b1 || bus.switch_pending !== 1'b0)
      begin fails++; $display("FAIL go_ocd: got sel=%b pend=%b want 1 0", bus.active_sel_ocd1_cpu0, bus.switch_pending); end
  endtask

  task automatic test_mid_frame;
    logic [9:0] fr;
    fr = {1'b1, 8'hA5, 1'b0};
    go_ocd();
    forced_cnt = 0;
    // Last space bit occupies frame cycles 28..31; old line idle 44 counts later, flip 47 after.
    for (int j = 0; j <= 78; j++) begin
      step((j < 40) ? fr[j/4] : 1'b1, 1'b1, (j >= 8) ? 1'b0 : 1'b1, 1'b0);
      tests++;
      if (j < 78) begin
        if (bus.active_sel_ocd1_cpu0 !== 1'b1 || bus.TXD !== ocd_p2)
          begin fails++; $display("FAIL frame[%0d]: got sel=%b txd=%b want 1 %b", j, bus.active_sel_ocd1_cpu0, bus.TXD, ocd_p2); end
      end else begin
        if (bus.active_sel_ocd1_cpu0 !== 1'b0 || bus.TXD !== 1'b1)
          begin fails++; $display("FAIL frame_switch: got sel=%b txd=%b want 0 1", bus.active_sel_ocd1_cpu0, bus.TXD); end
      end
    end
    tests++;
    if (forced_cnt != 0) begin fails++; $display("FAIL frame_forced: got %0d pulses want 0", forced_cnt); end
  endtask

  task automatic test_cancel;
    logic [9:0] fr;
    fr = {1'b1, 8'h3C, 1'b0};
    go_ocd();
    forced_cnt = 0;
    for (int j = 0; j < 50; j++) begin
      step((j < 40) ? fr[j/4] : 1'b1, 1'b1, (j >= 8 && j < 15) ? 1'b0 : 1'b1, 1'b0);
      tests++;
      if (bus.active_sel_ocd1_cpu0 !== 1'b1 || bus.TXD !== ocd_p2)
        begin fails++; $display("FAIL cancel[%0d]: got sel=%b txd=%b want 1 %b", j, bus.active_sel_ocd1_cpu0, bus.TXD, ocd_p2); end
      if (j == 9 || j == 17) begin
        tests++;
        if (bus.switch_pending !== (j == 9))
          begin fails++; $display("FAIL cancel_pend[%0d]: got %b want %b", j, bus.switch_pending, (j == 9)); end
      end
    end
    tests++;
    if (forced_cnt != 0) begin fails++; $display("FAIL cancel_forced: got %0d pulses want 0", forced_cnt); end
  endtask

  task automatic test_timeout;
    go_ocd();
    forced_cnt = 0;
    // Request drops at k=40; timeout counter reaches 80 one cycle after entry+80, pulse follows.
    for (int k = 0; k <= 123; k++) begin
      step(((k / 20) % 2) != 0, 1'b1, (k >= 40) ? 1'b0 : 1'b1, 1'b0);
      if (k >= 40 && k <= 121) begin
        tests++;
        if (bus.forced_switch !== 1'b0 || bus.active_sel_ocd1_cpu0 !== 1'b1 || bus.TXD !== ocd_p2)
          begin fails++; $display("FAIL to_wait[%0d]: got f=%b sel=%b txd=%b want 0 1 %b", k - 40, bus.forced_switch, bus.active_sel_ocd1_cpu0, bus.TXD, ocd_p2); end
      end else if (k == 122) begin
        tests++;
        if (bus.forced_switch !== 1'b1 || bus.active_sel_ocd1_cpu0 !== 1'b0)
          begin fails++; $display("FAIL to_pulse: got f=%b sel=%b want 1 0", bus.forced_switch, bus.active_sel_ocd1_cpu0); end
      end else if (k == 123) begin
        tests++;
        if (bus.forced_switch !== 1'b0) begin fails++; $display("FAIL to_pulse_len: got %b want 0", bus.forced_switch); end
      end
    end
    tests++;
    if (forced_cnt != 1) begin fails++; $display("FAIL to_count: got %0d pulses want 1", forced_cnt); end
  endtask

  task automatic test_reset_mid_guard;
    tests++;
    if (bus.switch_pending !== 1'b1) begin fails++; $display("FAIL rg_in_guard: got %b want 1", bus.switch_pending); end
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    tests++;
    if (bus.active_sel_ocd1_cpu0 !== 1'b1 || bus.TXD !== 1'b1 || bus.switch_pending !== 1'b0 || bus.forced_switch !== 1'b0)
      begin fails++; $display("FAIL rg_after: got sel=%b txd=%b pend=%b f=%b want 1 1 0 0", bus.active_sel_ocd1_cpu0, bus.TXD, bus.switch_pending, bus.forced_switch); end
    step(1'b1, 1'b1, 1'b1, 1'b0);
    tests++;
    if (bus.switch_pending !== 1'b0 || bus.active_sel_ocd1_cpu0 !== 1'b1)
      begin fails++; $display("FAIL rg_settle: got pend=%b sel=%b want 0 1", bus.switch_pending, bus.active_sel_ocd1_cpu0); end
  endtask

  initial begin
    sync_reset = 1'b1;
    bus.uart_tx_ocd = 1'b1;
    bus.uart_tx_cpu = 1'b1;
    bus.debug_uart_tx_sel_ocd1_cpu0 = 1'b1;
    ocd_p1 = 1'b1; ocd_p2 = 1'b1;
    cpu_p1 = 1'b1; cpu_p2 = 1'b1;
    test_reset();
    test_passthrough();
    test_clean_switch();
    test_mid_frame();
    test_cancel();
    test_timeout();
    test_reset_mid_guard();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
